// File: rtl/scanner_gen_if.sv
// Control and status bundle between a scanner_gen block and its controller.
// Latency: none (wires only).
// Backpressure: none; pulses and levels only, no handshake stalls.
interface scanner_gen_if #(
  parameter int PW = 4
);
  // Controller to scanner
  logic          whichScanner;
  logic          initialOn;
  logic          goToStandby;
  logic          startScan;
  logic          startTransfer;
  logic          flush;
  // Scanner to controller / peer
  logic [2:0]    state;
  logic [PW-1:0] buffer_progress;
  logic          readyToTransfer;
  logic          otherGoToStandby;
  logic          otherStartScan;
  logic          otherFlush;
  logic          overflow;
  logic          xfer_valid;
  logic          xfer_last;

  modport master (
    output whichScanner, initialOn, goToStandby, startScan, startTransfer, flush,
    input  state, buffer_progress, readyToTransfer, otherGoToStandby,
           otherStartScan, otherFlush, overflow, xfer_valid, xfer_last
  );

  modport slave (
    input  whichScanner, initialOn, goToStandby, startScan, startTransfer, flush,
    output state, buffer_progress, readyToTransfer, otherGoToStandby,
           otherStartScan, otherFlush, overflow, xfer_valid, xfer_last
  );
endinterface

// File: rtl/scanner_gen.sv
// Scanner buffer controller: fills a sample buffer, signals the peer scanner, drains on request.
// Latency: state/progress update on the sampling edge; peer pulses one cycle after the level is reached.
// Backpressure: none; startTransfer is ignored until the buffer reaches READY_AT, lost samples set overflow.
module scanner_gen #(
  parameter int DEPTH    = 10,
  parameter int PW       = 4,
  parameter int WAKE_AT  = 5,
  parameter int START_AT = 8,
  parameter int READY_AT = 9,
  parameter int SCAN_DIV = 4,
  parameter int XFER_DIV = 2
) (
  input logic          clk,
  input logic          reset,
  scanner_gen_if.slave bus
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_STANDBY  = 3'd1,
    S_SCANNING = 3'd2,
    S_FULL     = 3'd3,
    S_TRANSFER = 3'd4,
    S_FLUSH    = 3'd5
  } state_t;

  // One prescaler serves both sample and transfer rates, so size it for the slower one.
  localparam int MAXDIV = (SCAN_DIV > XFER_DIV) ? SCAN_DIV : XFER_DIV;
  localparam int CW     = (MAXDIV > 1) ? $clog2(MAXDIV) : 1;

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] XFER_LAST = CW'(XFER_DIV - 1);
  localparam logic [PW-1:0] DEPTH_L   = PW'(DEPTH);
  localparam logic [PW-1:0] WAKE_L    = PW'(WAKE_AT);
  localparam logic [PW-1:0] START_L   = PW'(START_AT);
  localparam logic [PW-1:0] READY_L   = PW'(READY_AT);
  localparam logic [PW-1:0] ONE_L     = PW'(1);

  state_t        state_q, state_d;
  logic [PW-1:0] prog_q, prog_d;
  logic [CW-1:0] presc_q, presc_d;
  logic          overflow_q, overflow_d;
  logic          xfer_valid_q, xfer_valid_d;
  logic          xfer_last_q, xfer_last_d;
  // Peer pulses are staged: *_pend marks the edge the level was reached, the pulse follows one edge later.
  logic          wake_pend_q, wake_pend_d;
  logic          start_pend_q, start_pend_d;
  logic          flush_pend_q, flush_pend_d;
  logic          other_gts_q, other_ss_q, other_flush_q;

  logic          ready;
  logic          scan_tick;
  logic          xfer_tick;
  logic [PW-1:0] prog_inc;

  assign ready     = ((state_q == S_SCANNING) || (state_q == S_FULL)) && (prog_q >= READY_L);
  assign scan_tick = (presc_q == SCAN_LAST);
  assign xfer_tick = (presc_q == XFER_LAST);
  assign prog_inc  = prog_q + ONE_L;

  // Next-state and datapath decisions, highest-priority input first.
  always_comb begin
    state_d      = state_q;
    prog_d       = prog_q;
    overflow_d   = overflow_q;
    xfer_valid_d = 1'b0;
    xfer_last_d  = 1'b0;
    wake_pend_d  = 1'b0;
    start_pend_d = 1'b0;
    flush_pend_d = 1'b0;

    case (state_q)
      S_OFF: begin
        // flush has nothing to discard here, so it is ignored.
        if (bus.goToStandby) begin
          state_d = S_STANDBY;
        end else if (bus.startScan) begin
          state_d = S_SCANNING;
        end else if (bus.initialOn && bus.whichScanner) begin
          state_d = S_SCANNING;
        end
      end

      S_STANDBY: begin
        if (bus.flush) begin
          state_d    = S_FLUSH;
          prog_d     = '0;
          overflow_d = 1'b0;
        end else if (bus.startScan) begin
          state_d = S_SCANNING;
        end
      end

      S_SCANNING: begin
        if (bus.flush) begin
          state_d    = S_FLUSH;
          prog_d     = '0;
          overflow_d = 1'b0;
        end else if (bus.startTransfer && ready) begin
          // A sample tick on the accepting edge is dropped on purpose.
          state_d = S_TRANSFER;
        end else if (scan_tick) begin
          prog_d = prog_inc;
          if (prog_inc == WAKE_L)  wake_pend_d  = 1'b1;
          if (prog_inc == START_L) start_pend_d = 1'b1;
          if (prog_inc >= DEPTH_L) state_d      = S_FULL;
        end
      end

      S_FULL: begin
        if (bus.flush) begin
          state_d    = S_FLUSH;
          prog_d     = '0;
          overflow_d = 1'b0;
        end else if (bus.startTransfer && ready) begin
          state_d = S_TRANSFER;
        end else if (scan_tick) begin
          overflow_d = 1'b1;
        end
      end

      S_TRANSFER: begin
        if (bus.flush) begin
          state_d    = S_FLUSH;
          prog_d     = '0;
          overflow_d = 1'b0;
        end else if (prog_q == '0) begin
          // Defensive: never underflow, just leave.
          state_d = S_STANDBY;
        end else if (xfer_tick) begin
          prog_d       = prog_q - ONE_L;
          xfer_valid_d = 1'b1;
          if (prog_q == ONE_L) begin
            xfer_last_d  = 1'b1;
            state_d      = S_STANDBY;
            flush_pend_d = overflow_q;
          end
        end
      end

      S_FLUSH: begin
        state_d = S_STANDBY;
      end

      default: begin
        state_d = S_OFF;
      end
    endcase
  end

  // Prescaler: restart on any state change, otherwise count at the rate of the current state.
  always_comb begin
    presc_d = '0;
    if (state_d == state_q) begin
      if ((state_q == S_SCANNING) || (state_q == S_FULL)) begin
        presc_d = scan_tick ? '0 : presc_q + CW'(1);
      end else if (state_q == S_TRANSFER) begin
        presc_d = xfer_tick ? '0 : presc_q + CW'(1);
      end
    end
  end

  // State and output registers; reset clears everything including staged peer pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_OFF;
      prog_q        <= '0;
      presc_q       <= '0;
      overflow_q    <= 1'b0;
      xfer_valid_q  <= 1'b0;
      xfer_last_q   <= 1'b0;
      wake_pend_q   <= 1'b0;
      start_pend_q  <= 1'b0;
      flush_pend_q  <= 1'b0;
      other_gts_q   <= 1'b0;
      other_ss_q    <= 1'b0;
      other_flush_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prog_q        <= prog_d;
      presc_q       <= presc_d;
      overflow_q    <= overflow_d;
      xfer_valid_q  <= xfer_valid_d;
      xfer_last_q   <= xfer_last_d;
      wake_pend_q   <= wake_pend_d;
      start_pend_q  <= start_pend_d;
      flush_pend_q  <= flush_pend_d;
      other_gts_q   <= wake_pend_q;
      other_ss_q    <= start_pend_q;
      other_flush_q <= flush_pend_q;
    end
  end

  assign bus.state            = state_q;
  assign bus.buffer_progress  = prog_q;
  assign bus.readyToTransfer  = ready;
  assign bus.overflow         = overflow_q;
  assign bus.xfer_valid       = xfer_valid_q;
  assign bus.xfer_last        = xfer_last_q;
  assign bus.otherGoToStandby = other_gts_q;
  assign bus.otherStartScan   = other_ss_q;
  assign bus.otherFlush       = other_flush_q;

endmodule

// File: tb/tb_scanner_gen.sv
// Bench for scanner_gen: default-parameter instance driven by a vector table plus
// hand sequences for transfer, flush and reset-abort; second instance for the fast sweep.
module tb_scanner_gen;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scanner_gen_if #(.PW(4)) bus_a ();
  scanner_gen_if #(.PW(5)) bus_b ();

  scanner_gen dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a.slave)
  );

  scanner_gen #(
    .DEPTH(20), .PW(5), .WAKE_AT(5), .START_AT(8), .READY_AT(9),
    .SCAN_DIV(1), .XFER_DIV(1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b.slave)
  );

  // Peer-pulse monitor for instance A: cycle at which progress reaches a level, and pulse cycles.
  int       wake_cyc = -100, ogs_cyc = -100, ogs_cnt = 0;
  int       start_cyc = -100, oss_cyc = -100, oss_cnt = 0;
  logic [3:0] prev_prog = '0;
  always @(negedge clk) begin
    if (bus_a.buffer_progress == 4'd5 && prev_prog == 4'd4) wake_cyc  = cyc;
    if (bus_a.buffer_progress == 4'd8 && prev_prog == 4'd7) start_cyc = cyc;
    if (bus_a.otherGoToStandby) begin ogs_cnt++; ogs_cyc = cyc; end
    if (bus_a.otherStartScan)   begin oss_cnt++; oss_cyc = cyc; end
    prev_prog = bus_a.buffer_progress;
  end

  typedef struct {
    string      name;
    logic       ws, ion, gts, ss, st, fl, rst;
    int         idle;
    logic [2:0] e_state;
    logic [3:0] e_prog;
    logic       e_ready;
    logic       e_ovf;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(string n, logic ws, logic ion, logic gts, logic ss, logic st,
                              logic fl, logic rst, int idle, logic [2:0] es, logic [3:0] ep,
                              logic er, logic eo);
    vec_t v;
    v.name = n; v.ws = ws; v.ion = ion; v.gts = gts; v.ss = ss; v.st = st; v.fl = fl;
    v.rst = rst; v.idle = idle; v.e_state = es; v.e_prog = ep; v.e_ready = er; v.e_ovf = eo;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_a();
    bus_a.initialOn = 0; bus_a.goToStandby = 0; bus_a.startScan = 0;
    bus_a.startTransfer = 0; bus_a.flush = 0; rst_a = 0;
  endtask

  int nv, nlast, nfl, fl_off, gap_err, last_idx, t0, first_off, last_off;

  initial begin
    bus_a.whichScanner = 0; bus_a.initialOn = 0; bus_a.goToStandby = 0;
    bus_a.startScan = 0; bus_a.startTransfer = 0; bus_a.flush = 0;
    bus_b.whichScanner = 1; bus_b.initialOn = 0; bus_b.goToStandby = 0;
    bus_b.startScan = 0; bus_b.startTransfer = 0; bus_b.flush = 0;
    step(3);

    // Reset state
    chk("rst.state", bus_a.state, 0);
    chk("rst.prog", bus_a.buffer_progress, 0);
    chk("rst.ready", bus_a.readyToTransfer, 0);
    chk("rst.ovf", bus_a.overflow, 0);
    chk("rst.pulses", {bus_a.xfer_valid, bus_a.xfer_last, bus_a.otherFlush,
                       bus_a.otherGoToStandby, bus_a.otherStartScan}, 0);
    rst_a = 0; rst_b = 0;

    //        name                ws ion gts ss st fl rst idle st prog rdy ovf
    tv.push_back(mk("ws0_initialOn",   0, 1, 0, 0, 0, 0, 0,  2, 3'd0, 4'd0,  0, 0));
    tv.push_back(mk("goToStandby",     0, 0, 1, 0, 0, 0, 0,  0, 3'd1, 4'd0,  0, 0));
    tv.push_back(mk("stby_gts_ignored",0, 0, 1, 0, 0, 0, 0,  0, 3'd1, 4'd0,  0, 0));
    tv.push_back(mk("flush_stby",      0, 0, 0, 0, 0, 1, 0,  0, 3'd5, 4'd0,  0, 0));
    tv.push_back(mk("flush_held",      0, 0, 0, 0, 0, 1, 0,  0, 3'd1, 4'd0,  0, 0));
    tv.push_back(mk("reset_stby",      0, 0, 0, 0, 0, 0, 1,  0, 3'd0, 4'd0,  0, 0));
    tv.push_back(mk("flush_off_ign",   0, 0, 0, 0, 0, 1, 0,  0, 3'd0, 4'd0,  0, 0));
    tv.push_back(mk("initialOn_ws1",   1, 1, 0, 0, 0, 0, 0,  3, 3'd2, 4'd0,  0, 0));
    tv.push_back(mk("first_sample",    1, 0, 0, 0, 0, 0, 0,  0, 3'd2, 4'd1,  0, 0));
    tv.push_back(mk("prog7",           1, 0, 0, 0, 0, 0, 0, 23, 3'd2, 4'd7,  0, 0));
    tv.push_back(mk("st_at7_ignored",  1, 0, 0, 0, 1, 0, 0,  0, 3'd2, 4'd7,  0, 0));
    tv.push_back(mk("prog9_ready",     1, 0, 0, 0, 0, 0, 0,  6, 3'd2, 4'd9,  1, 0));
    tv.push_back(mk("prog10_full",     1, 0, 0, 0, 0, 0, 0,  3, 3'd3, 4'd10, 1, 0));
    tv.push_back(mk("full_hold8",      1, 0, 0, 0, 0, 0, 0,  7, 3'd3, 4'd10, 1, 1));

    foreach (tv[i]) begin
      bus_a.whichScanner = tv[i].ws; bus_a.initialOn = tv[i].ion;
      bus_a.goToStandby = tv[i].gts; bus_a.startScan = tv[i].ss;
      bus_a.startTransfer = tv[i].st; bus_a.flush = tv[i].fl; rst_a = tv[i].rst;
      step(1);
      clear_a();
      step(tv[i].idle);
      chk($sformatf("%s.state", tv[i].name), bus_a.state, tv[i].e_state);
      chk($sformatf("%s.prog", tv[i].name), bus_a.buffer_progress, tv[i].e_prog);
      chk($sformatf("%s.ready", tv[i].name), bus_a.readyToTransfer, tv[i].e_ready);
      chk($sformatf("%s.ovf", tv[i].name), bus_a.overflow, tv[i].e_ovf);
    end

    // Peer pulses: once each, one cycle after the level is reached
    chk("ogs.count", ogs_cnt, 1);
    chk("ogs.delay", ogs_cyc - wake_cyc, 1);
    chk("oss.count", oss_cnt, 1);
    chk("oss.delay", oss_cyc - start_cyc, 1);

    // Drain from FULL with overflow set
    bus_a.startTransfer = 1; step(1); clear_a();
    t0 = cyc;
    chk("xfer.entry_state", bus_a.state, 4);
    chk("xfer.entry_prog", bus_a.buffer_progress, 10);
    nv = 0; nlast = 0; nfl = 0; fl_off = -1; gap_err = 0; last_idx = 0;
    for (int k = 0; k < 24; k++) begin
      step(1);
      if (bus_a.xfer_valid) begin
        nv++;
        if (cyc - t0 != 2 * nv) gap_err++;
        if (bus_a.xfer_last) last_idx = nv;
      end
      if (bus_a.xfer_last) nlast++;
      if (bus_a.otherFlush) begin nfl++; fl_off = cyc - t0; end
    end
    chk("xfer.count", nv, 10);
    chk("xfer.spacing_errs", gap_err, 0);
    chk("xfer.last_count", nlast, 1);
    chk("xfer.last_idx", last_idx, 10);
    chk("xfer.otherFlush_count", nfl, 1);
    chk("xfer.otherFlush_offset", fl_off, 21);
    chk("xfer.end_state", bus_a.state, 1);
    chk("xfer.end_prog", bus_a.buffer_progress, 0);
    chk("xfer.ovf_kept", bus_a.overflow, 1);

    // startTransfer together with flush at progress 9
    bus_a.startScan = 1; step(1); clear_a();
    chk("rescan.state", bus_a.state, 2);
    step(36);
    chk("rescan.prog9", bus_a.buffer_progress, 9);
    bus_a.startTransfer = 1; bus_a.flush = 1; step(1); clear_a();
    chk("stfl.state", bus_a.state, 5);
    chk("stfl.prog", bus_a.buffer_progress, 0);
    chk("stfl.ovf", bus_a.overflow, 0);
    step(1);
    chk("stfl.after_state", bus_a.state, 1);

    // Transfer accepted on a sample-tick edge drops that sample; then reset aborts mid-transfer
    bus_a.startScan = 1; step(1); clear_a();
    step(39);
    chk("tick_drop.pre_prog", bus_a.buffer_progress, 9);
    bus_a.startTransfer = 1; step(1); clear_a();
    chk("tick_drop.state", bus_a.state, 4);
    chk("tick_drop.prog", bus_a.buffer_progress, 9);
    step(7);
    chk("abort.pre_prog", bus_a.buffer_progress, 6);
    rst_a = 1; step(1);
    chk("abort.state", bus_a.state, 0);
    chk("abort.prog", bus_a.buffer_progress, 0);
    chk("abort.xv_on_edge", bus_a.xfer_valid, 0);
    rst_a = 0;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (bus_a.xfer_valid || bus_a.xfer_last || bus_a.otherFlush) nv++;
    end
    chk("abort.pulses_after", nv, 0);
    chk("abort.state_after", bus_a.state, 0);

    // Fast sweep on instance B
    bus_b.initialOn = 1; step(1); bus_b.initialOn = 0;
    chk("sweep.entry_state", bus_b.state, 2);
    step(19);
    chk("sweep.prog19_state", bus_b.state, 2);
    chk("sweep.prog19", bus_b.buffer_progress, 19);
    step(1);
    chk("sweep.full_state", bus_b.state, 3);
    chk("sweep.full_prog", bus_b.buffer_progress, 20);
    bus_b.startTransfer = 1; step(1); bus_b.startTransfer = 0;
    t0 = cyc;
    nv = 0; nlast = 0; first_off = -1; last_off = -1; last_idx = 0;
    for (int k = 0; k < 24; k++) begin
      step(1);
      if (bus_b.xfer_valid) begin
        nv++;
        if (first_off < 0) first_off = cyc - t0;
        last_off = cyc - t0;
        if (bus_b.xfer_last) last_idx = nv;
      end
      if (bus_b.xfer_last) nlast++;
    end
    chk("sweep.xfer_count", nv, 20);
    chk("sweep.first_offset", first_off, 1);
    chk("sweep.last_offset", last_off, 20);
    chk("sweep.last_idx", last_idx, 20);
    chk("sweep.last_count", nlast, 1);
    chk("sweep.end_state", bus_b.state, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scanner_gen.md
SCANNER_GEN -- requirements
Module: scanner_gen

Interface
REQ-001 Parameter DEPTH, default 10: buffer capacity in samples.
REQ-002 Parameter PW, default 4: progress width; 2^PW SHALL exceed DEPTH.
REQ-003 Parameter WAKE_AT, default 5: fill level that wakes the peer scanner.
REQ-004 Parameter START_AT, default 8: fill level that starts the peer scanner.
REQ-005 Parameter READY_AT, default 9: fill level at which transfer is permitted; 0<WAKE_AT<START_AT<=READY_AT<=DEPTH.
REQ-006 Parameter SCAN_DIV, default 4: clock cycles per captured sample, >=1.
REQ-007 Parameter XFER_DIV, default 2: clock cycles per transferred sample, >=1.
REQ-008 clk  in  1  single system clock, rising-edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 whichScanner  in  1  1 = primary scanner, 0 = secondary.
REQ-011 initialOn  in  1  power-on request, honoured only when whichScanner=1.
REQ-012 goToStandby  in  1  peer request to leave OFF for STANDBY.
REQ-013 startScan  in  1  peer request to begin scanning.
REQ-014 startTransfer  in  1  host request to drain the buffer.
REQ-015 flush  in  1  discard buffer contents.
REQ-016 state  out  3  current state: OFF=0, STANDBY=1, SCANNING=2, FULL=3, TRANSFER=4, FLUSH=5.
REQ-017 buffer_progress  out  PW  samples currently held, 0..DEPTH.
REQ-018 readyToTransfer  out  1  high while state is SCANNING or FULL and buffer_progress>=READY_AT.
REQ-019 otherGoToStandby, otherStartScan, otherFlush  out  1 each  one-cycle pulses to the peer scanner.
REQ-020 overflow  out  1  sticky flag: at least one sample was lost.
REQ-021 xfer_valid, xfer_last  out  1 each  pulse per transferred sample; xfer_last marks the final sample.

Function
REQ-022 All transitions SHALL occur on the rising clk edge at which the causing input is sampled high.
REQ-023 Input priority SHALL be flush > goToStandby > startTransfer > startScan > initialOn.
REQ-024 Transitions from OFF: goToStandby goes to STANDBY; startScan goes to SCANNING; initialOn with whichScanner=1 goes to SCANNING.
REQ-025 Transitions from STANDBY: startScan goes to SCANNING; goToStandby is ignored.
REQ-026 An internal prescaler SHALL clear on every state entry; a tick occurs on each edge where prescaler=DIV-1, then the prescaler wraps to 0.
REQ-027 In SCANNING, each SCAN_DIV tick increments buffer_progress; the first increment occurs SCAN_DIV cycles after entry.
REQ-028 otherGoToStandby SHALL pulse for exactly one cycle, on the cycle after buffer_progress becomes WAKE_AT.
REQ-029 otherStartScan SHALL pulse for exactly one cycle, on the cycle after buffer_progress becomes START_AT.
REQ-030 When buffer_progress reaches DEPTH, the block SHALL enter FULL on the same edge.
REQ-031 In FULL, each SCAN_DIV tick sets overflow; buffer_progress holds at DEPTH.
REQ-032 startTransfer is accepted only while readyToTransfer=1; otherwise it is ignored.
REQ-033 On accepting startTransfer, the block SHALL enter TRANSFER and discard any sample tick on that same edge.
REQ-034 In TRANSFER, each XFER_DIV tick pulses xfer_valid and decrements buffer_progress.
REQ-035 xfer_last SHALL accompany the xfer_valid pulse that takes buffer_progress from 1 to 0; on that edge the state goes to STANDBY.
REQ-036 If overflow=1 at TRANSFER completion, otherFlush SHALL pulse on the next cycle; overflow itself remains set.
REQ-037 While TRANSFER is active, startScan and startTransfer are ignored.
REQ-038 flush in any state other than OFF SHALL enter FLUSH; on that edge buffer_progress goes to 0 and overflow is cleared.
REQ-039 FLUSH lasts exactly one cycle, then goes to STANDBY, even if flush remains high.
REQ-040 flush in OFF is ignored.
REQ-041 buffer_progress SHALL never wrap: it never exceeds DEPTH and never decrements below 0.

Reset
REQ-042 While reset=1 at an edge: state=OFF, buffer_progress=0, prescaler=0, overflow=0, and all pulse outputs and readyToTransfer are 0.
REQ-043 Reset asserted mid-SCANNING or mid-TRANSFER SHALL abort the operation with no pulses emitted on the reset edge or after it.

Verification
REQ-044 Default parameters, whichScanner=1, pulse initialOn for 1 cycle: state=2; buffer_progress=1 after 4 cycles; otherGoToStandby pulses once after progress=5; otherStartScan pulses once after progress=8; readyToTransfer=1 at progress 9; state=3 at progress 10.
REQ-045 whichScanner=0, pulse initialOn: state stays 0; then pulse goToStandby: state=1.
REQ-046 Hold in FULL for 8 cycles -> overflow=1; startTransfer -> exactly 10 xfer_valid pulses 2 cycles apart, xfer_last on the 10th, state=1, otherFlush pulses once.
REQ-047 startTransfer at progress 7 -> ignored, scanning continues; startTransfer together with flush at progress 9 -> state=5, then 1, progress=0, overflow=0.
REQ-048 reset at progress 6 of TRANSFER -> state=0, progress=0, no xfer_valid pulse afterwards.
REQ-049 Parameter sweep DEPTH=20, PW=5, SCAN_DIV=1, XFER_DIV=1: 20 cycles from SCANNING entry to FULL; 20 consecutive xfer_valid pulses.
